spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
//  SPI mode-0 write-only controller; drives the register-write link into the on-chip SPI peripheral (sclk/ncs/copi).
//  Accepts one write command (7-bit addr, 8-bit data) per valid/ready handshake.
//  Serialises a 16-bit frame MSB first: {1'b1 (write), addr[6:0], data[7:0]}.
//  Used by the bring-up sequencer and testbench as the bus master.
// PARAMETERS
//  CLK_DIV   4  clk cycles per sclk half-period; must be >=4 (peripheral's 3-stage sync); elaboration $error otherwise
//  CS_SETUP  2  clk cycles ncs low with sclk low before the first sclk rise; >=1
//  CS_HOLD   2  clk cycles after the last sclk fall before ncs deasserts; >=1
//  CS_IDLE   4  clk cycles ncs high after a frame before the next accept; >=1
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  synchronous reset, active-high (asserted = 1)
//  cmd_valid  in   1  command present
//  cmd_ready  out  1  controller can accept; high only in IDLE
//  cmd_addr   in   7  register address (sent unmodified; peripheral ignores >0x04)
//  cmd_data   in   8  register data
//  busy       out  1  high from accept cycle+1 through end of IDLE-gap
//  done       out  1  one-cycle pulse in the cycle ncs returns high
//  sclk       out  1  serial clock, idles low
//  ncs        out  1  chip select, active low, idles high
//  copi       out  1  serial data, MSB first
// BEHAVIOUR
//  Reset (rst_n=1 at posedge): state=IDLE; sclk=0, ncs=1, copi=0, busy=0, done=0, cmd_ready=0 while asserted, 1 cycle after release.
//  Reset mid-frame: same values next cycle; frame abandoned, no done pulse.
//  Accept: cmd_valid && cmd_ready at edge T; frame {1,addr,data} latched into shift reg; cmd_* ignored thereafter.
//  FSM IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE:
//   SETUP: from T+1, ncs=0, sclk=0, copi=frame[15]; lasts CS_SETUP cycles.
//   SHIFT: 16 bit periods; each = CLK_DIV cycles sclk=0 then CLK_DIV cycles sclk=1.
//     copi changes only when sclk falls (or on SETUP entry); stable through whole low+high phase.
//     bit counter 0..15 (5 bits); after the 16th high phase sclk=0 and state->HOLD (copi=0).
//   HOLD: CS_HOLD cycles, ncs=0, sclk=0.
//   GAP: first cycle ncs=1, done=1; CS_IDLE cycles total; cmd_ready=0.
//  ncs low duration = CS_SETUP + 32*CLK_DIV + CS_HOLD cycles (defaults: 132).
//  Accept-to-accept minimum = 1 + that + CS_IDLE (defaults: 137).
//  sclk exactly 16 rising edges per frame; never high while ncs=1.
//  cmd_valid held during busy: no effect; accepted on first IDLE cycle (back-to-back).
//  Divider counter width $clog2(CLK_DIV); wraps to 0 at CLK_DIV-1 and toggles sclk.
//  All outputs registered; no combinational path cmd_* -> serial pins.
// STRUCTURE
//  spi_pkg (shared with spi_peripheral): SPI_FRAME_W=16, SPI_ADDR_W=7, SPI_DATA_W=8,
//   SPI_WRITE_BIT=1'b1, address constants ADDR_EN_OUT_7_0=7'h00 .. ADDR_PWM_DUTY=7'h04, FSM state enum.
//  Sub-module spi_sclk_gen: divider + sclk register, emits rise/fall strobes; enable from FSM.
// TESTING (defaults CLK_DIV=4, CS_SETUP=2, CS_HOLD=2, CS_IDLE=4)
//  1 addr=0x04 data=0x80 -> copi sampled at 16 sclk rises = 0x8480; ncs low 132 cycles; one done pulse.
//  2 Loopback into spi_peripheral: write 0x00/0xA5, 0x03/0x3C -> en_reg_out_7_0=0xA5, en_reg_pwm_15_8=0x3C.
//  3 cmd_valid held high, two cmds -> second accepted exactly CS_IDLE cycles after done; cmd_ready low between.
//  4 Reset asserted at 5th sclk rise -> next cycle ncs=1, sclk=0, copi=0, no done; peripheral regs unchanged.
//  5 addr=0x05 data=0xFF -> frame 0x85FF sent normally; peripheral registers unchanged.
//  6 Assertion monitor all tests: copi stable while sclk=1; sclk=0 whenever ncs=1; 16 rises per ncs-low window.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI write-link definitions: frame geometry, register map and controller state encoding.
// Used by the controller and by the peripheral on the far side of the link.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;

  localparam logic SPI_WRITE_BIT = 1'b1;

  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  function automatic logic [SPI_FRAME_W-1:0] spi_frame(input logic [SPI_ADDR_W-1:0] addr,
                                                       input logic [SPI_DATA_W-1:0] data);
    return {SPI_WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: sclk idles low while disabled, toggles every CLK_DIV cycles once enabled.
// Rise/fall strobes are high in the cycle before the registered sclk edge appears.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             r_sclk;
  logic             w_wrap;

  assign w_wrap = i_en && (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_div  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  assign o_sclk = r_sclk;
  assign o_rise = w_wrap && !r_sclk;
  assign o_fall = w_wrap && r_sclk;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only master: one {1,addr,data} frame per accepted command, all outputs registered.
// cmd_ready is high only in IDLE; accept-to-accept is 1 + ncs-low time + CS_IDLE cycles.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SPI_ADDR_W-1:0] cmd_addr,
  input  logic [SPI_DATA_W-1:0] cmd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  ncs,
  output logic                  copi
);

  localparam int MAX_T_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_T   = (MAX_T_A > CS_IDLE) ? MAX_T_A : CS_IDLE;
  localparam int CNT_W   = $clog2(MAX_T + 1);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be >= 4");
  end
  if (CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_bad_cs_timing
    $error("spi_controller: CS_SETUP, CS_HOLD and CS_IDLE must be >= 1");
  end

  spi_state_t             r_state;
  spi_state_t             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_lim;
  logic [4:0]             r_rises;
  logic [SPI_FRAME_W-1:0] r_shift;
  logic                   r_ncs;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_accept;
  logic                   w_sclk_en;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_last_fall;
  logic                   w_cnt_done;
  logic                   w_ncs_low_nxt;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_en  (w_sclk_en),
    .o_sclk(sclk),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  // r_ready gates acceptance so the first cycle after reset release never accepts.
  assign w_accept    = (r_state == ST_IDLE) && cmd_valid && r_ready;
  assign w_sclk_en   = (r_state == ST_SHIFT);
  assign w_last_fall = w_fall && (r_rises == 5'd16);
  assign w_cnt_done  = (r_cnt == w_cnt_lim);

  always_comb begin
    w_cnt_lim = '0;
    case (r_state)
      ST_SETUP: w_cnt_lim = CNT_W'(CS_SETUP - 1);
      ST_HOLD:  w_cnt_lim = CNT_W'(CS_HOLD - 1);
      ST_GAP:   w_cnt_lim = CNT_W'(CS_IDLE - 1);
      default:  w_cnt_lim = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)    w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_cnt_done)  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last_fall) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_cnt_done)  w_state_nxt = ST_GAP;
      ST_GAP:   if (w_cnt_done)  w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ncs_low_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT) ||
                         (w_state_nxt == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rises <= '0;
      r_shift <= '0;
      r_ncs   <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_state == ST_SETUP || r_state == ST_HOLD || r_state == ST_GAP) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // copi is r_shift MSB: it moves only on sclk falls and clears after the final fall.
      if (w_accept) begin
        r_shift <= spi_frame(cmd_addr, cmd_data);
        r_rises <= '0;
      end else if (r_state == ST_SHIFT) begin
        if (w_rise) begin
          r_rises <= r_rises + 1'b1;
        end
        if (w_last_fall) begin
          r_shift <= '0;
        end else if (w_fall) begin
          r_shift <= {r_shift[SPI_FRAME_W-2:0], 1'b0};
        end
      end

      r_ncs   <= !w_ncs_low_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (r_state == ST_HOLD) && (w_state_nxt == ST_GAP);
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ncs       = r_ncs;
  assign copi      = r_shift[SPI_FRAME_W-1];

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: vector table, back-to-back, mid-frame reset and random frames,
// with a pin-level frame capture and register-file reference model.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;
  localparam int NCS_LOW  = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
  localparam int ACC2ACC  = 1 + NCS_LOW + CS_IDLE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, busy, done, sclk, ncs, copi;

  always #5 clk = ~clk;

  spi_controller #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_IDLE (CS_IDLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .busy     (busy),
    .done     (done),
    .sclk     (sclk),
    .ncs      (ncs),
    .copi     (copi)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Pin-level observer: captures bits at sclk rises, measures ncs-low windows,
  // and plays the peripheral's register file.
  logic        p_sclk = 1'b0, p_ncs = 1'b1, p_copi = 1'b0;
  logic [15:0] cap = '0;
  int          rises = 0, low_len = 0, done_cnt = 0, idx;
  bit          aborting = 1'b1;
  logic [15:0] frames_q[$];
  int          len_q[$];
  logic [7:0]  dev_regs[5] = '{default: 8'h00};
  logic [7:0]  exp_regs[5] = '{default: 8'h00};

  always @(negedge clk) begin
    if (p_ncs && !ncs) begin
      rises   = 0;
      low_len = 0;
      cap     = '0;
    end
    if (!aborting) begin
      if (ncs) check("sclk_low_while_ncs_high", {31'd0, sclk}, 32'd0);
      if (!(p_sclk && !sclk) && !(p_ncs && !ncs))
        check("copi_stable_outside_fall", {31'd0, copi}, {31'd0, p_copi});
      if (done) check("done_only_at_ncs_rise", {31'd0, ncs && !p_ncs}, 32'd1);
      if (ncs && !p_ncs) check("done_with_ncs_rise", {31'd0, done}, 32'd1);
    end
    if (!p_sclk && sclk) begin
      cap = {cap[14:0], copi};
      rises++;
    end
    if (!ncs) low_len++;
    if (done) done_cnt++;
    if (ncs && !p_ncs && !aborting) begin
      check("rises_per_frame", rises, 16);
      frames_q.push_back(cap);
      len_q.push_back(low_len);
      idx = int'(cap[14:8]);
      if (rises == 16 && cap[15] && idx <= 4) dev_regs[idx] = cap[7:0];
    end
    p_sclk = sclk;
    p_ncs  = ncs;
    p_copi = copi;
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("cmd_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [6:0] a, input logic [7:0] d, output int acc_cyc);
    bit ok;
    @(negedge clk);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    wait_ready(ok);
    acc_cyc = -1;
    if (ok) begin
      check("busy_low_in_idle", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      cmd_valid = 1'b0;
      cmd_addr  = 7'($urandom);
      cmd_data  = 8'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_frame(input logic [15:0] exp);
    if (frames_q.size() == 0) begin
      check("frame_captured", 32'd0, 32'd1);
    end else begin
      check("frame_bits", {16'd0, frames_q.pop_front()}, {16'd0, exp});
      check("ncs_low_cycles", len_q.pop_front(), NCS_LOW);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 5; i++) check("periph_reg", {24'd0, dev_regs[i]}, {24'd0, exp_regs[i]});
  endtask

  task automatic run_frame(input logic [6:0] a, input logic [7:0] d, input logic [15:0] exp);
    int t_acc, t_done, dc0;
    dc0 = done_cnt;
    send(a, d, t_acc);
    check("ready_low_after_accept", {31'd0, cmd_ready}, 32'd0);
    wait_done(t_done);
    if (a <= 7'd4) exp_regs[a] = d;
    check_frame(exp);
    check("accept_to_done", t_done - t_acc, NCS_LOW);
    check("done_pulse_count", done_cnt - dc0, 1);
    check_regs();
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0, t1, td, tdummy, dc0, seen;
    bit ok;
    logic [6:0] ra;
    logic [7:0] rd;

    vecs[0] = '{7'h04, 8'h80, 16'h8480};
    vecs[1] = '{7'h00, 8'hA5, 16'h80A5};
    vecs[2] = '{7'h03, 8'h3C, 16'h833C};
    vecs[3] = '{7'h05, 8'hFF, 16'h85FF};
    vecs[4] = '{7'h7F, 8'h00, 16'hFF00};
    vecs[5] = '{7'h01, 8'h5A, 16'h815A};

    // Reset state, then one cycle of latency to cmd_ready after release.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_ncs", {31'd0, ncs}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_copi", {31'd0, copi}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("ready_after_release", {31'd0, cmd_ready}, 32'd1);
    aborting = 1'b0;

    for (int v = 0; v < 6; v++) run_frame(vecs[v].addr, vecs[v].data, vecs[v].frame);

    // cmd_valid held high across two commands.
    dc0 = done_cnt;
    @(negedge clk);
    cmd_addr  = 7'h02;
    cmd_data  = 8'h11;
    cmd_valid = 1'b1;
    wait_ready(ok);
    @(posedge clk);
    #1;
    t0       = cyc;
    cmd_addr = 7'h01;
    cmd_data = 8'h22;
    @(negedge clk);
    check("b2b_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("b2b_busy_high", {31'd0, busy}, 32'd1);
    td   = -1000;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) td = cyc;
      if (cmd_ready === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("b2b_ready_seen", seen, 1);
    check("b2b_done_to_ready", cyc - td, CS_IDLE);
    @(posedge clk);
    #1;
    t1        = cyc;
    cmd_valid = 1'b0;
    check("b2b_accept_to_accept", t1 - t0, ACC2ACC);
    wait_done(tdummy);
    exp_regs[2] = 8'h11;
    exp_regs[1] = 8'h22;
    check_frame(16'h8211);
    check_frame(16'h8122);
    check("b2b_done_count", done_cnt - dc0, 2);
    check_regs();

    // Randomised commands against the arithmetic frame/register model.
    for (int n = 0; n < 14; n++) begin
      ra = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(0, 127));
      rd = 8'($urandom_range(0, 255));
      run_frame(ra, rd, 16'(32768 + int'(ra) * 256 + int'(rd)));
    end

    // Reset at the 5th sclk rise abandons the frame.
    dc0 = done_cnt;
    send(7'h00, 8'hC3, tdummy);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rises >= 5) begin
        seen = 1;
        break;
      end
    end
    check("abort_reached_rise5", seen, 1);
    aborting = 1'b1;
    rst_n    = 1'b1;
    @(negedge clk);
    check("abort_ncs", {31'd0, ncs}, 32'd1);
    check("abort_sclk", {31'd0, sclk}, 32'd0);
    check("abort_copi", {31'd0, copi}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready_after_release", {31'd0, cmd_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - dc0, 0);
    check("abort_no_frame", frames_q.size(), 0);
    check_regs();
    aborting = 1'b0;

    run_frame(7'h04, 8'h80, 16'h8480);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
